// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC, decodes read/write frames,
// serves a minimal PHY register set and reports committed writes.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0DD1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        link_up,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_OPCODE, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  localparam logic [5:0]  PRE_MIN  = 6'(PREAMBLE_MIN);
  localparam logic [5:0]  CNT_MAX  = 6'd32;
  localparam logic [15:0] CTRL_DEF = 16'h1140;
  localparam logic [15:0] STATUS   = 16'h7949;

  // Sync flops reset to 1 so an MDC/MDIO held high across reset is not seen as an edge.
  logic [1:0] r_mdc_s;
  logic [1:0] r_mdio_s;
  logic       r_mdc_prev;
  logic       w_edge;
  logic       w_sd;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_mdc_s    <= 2'b11;
      r_mdio_s   <= 2'b11;
      r_mdc_prev <= 1'b1;
    end else begin
      r_mdc_s    <= {r_mdc_s[0], mdc};
      r_mdio_s   <= {r_mdio_s[0], mdio_in};
      r_mdc_prev <= r_mdc_s[1];
    end
  end

  assign w_edge = r_mdc_s[1] & ~r_mdc_prev;
  assign w_sd   = r_mdio_s[1];

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_op;
  logic [3:0]  r_phy;
  logic        r_match;
  logic [4:0]  r_regad;
  logic [15:0] r_rdata;
  logic [14:0] r_wdata;
  logic [15:0] r_reg0;
  logic [15:0] r_rw [4];
  logic        r_oen, r_out;
  logic        r_wr_valid;
  logic [4:0]  r_wr_addr;
  logic [15:0] r_wr_data;

  logic        w_rd, w_wr;
  logic [4:0]  w_ra;
  logic [15:0] w_rd_mux;
  logic [15:0] w_wdat;

  assign w_rd   = r_match && (r_op == 2'b10);
  assign w_wr   = r_match && (r_op == 2'b01);
  assign w_ra   = {r_regad[3:0], w_sd};
  assign w_wdat = {r_wdata, w_sd};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_bit   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // r_bit holds the frame index of the bit sampled at the next MDC edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    if (w_edge) begin
      if (r_state != S_IDLE) w_bit_nxt = r_bit + 5'd1;
      case (r_state)
        S_IDLE: begin
          if (w_sd) begin
            if (r_cnt < CNT_MAX) w_cnt_nxt = r_cnt + 6'd1;
          end else if (r_cnt >= PRE_MIN) begin
            w_state_nxt = S_START;
            w_bit_nxt   = 5'd1;
          end else begin
            w_cnt_nxt = 6'd0;
          end
        end
        S_START: begin
          if (w_sd) begin
            w_state_nxt = S_OPCODE;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
          end
        end
        S_OPCODE: begin
          if (r_bit == 5'd3) begin
            if (r_op[0] ^ w_sd) begin
              w_state_nxt = S_PHYAD;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = 6'd0;
            end
          end
        end
        S_PHYAD: if (r_bit == 5'd8)  w_state_nxt = S_REGAD;
        S_REGAD: if (r_bit == 5'd13) w_state_nxt = S_TA;
        S_TA:    if (r_bit == 5'd15) w_state_nxt = S_DATA;
        S_DATA: begin
          if (r_bit == 5'd31) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = 16'h0000;
    case (w_ra)
      5'd0:                   w_rd_mux = r_reg0;
      5'd1:                   w_rd_mux = {STATUS[15:3], link_up, STATUS[1:0]};
      5'd2:                   w_rd_mux = PHY_ID1;
      5'd3:                   w_rd_mux = PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7: w_rd_mux = r_rw[w_ra[1:0]];
      default:                w_rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_op       <= 2'b00;
      r_phy      <= 4'd0;
      r_match    <= 1'b0;
      r_regad    <= 5'd0;
      r_rdata    <= 16'h0000;
      r_wdata    <= 15'd0;
      r_reg0     <= CTRL_DEF;
      for (int i = 0; i < 4; i++) r_rw[i] <= 16'h0000;
      r_oen      <= 1'b1;
      r_out      <= 1'b1;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 5'd0;
      r_wr_data  <= 16'h0000;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_edge) begin
        case (r_state)
          S_OPCODE: r_op <= {r_op[0], w_sd};
          S_PHYAD: begin
            r_phy <= {r_phy[2:0], w_sd};
            if (r_bit == 5'd8) r_match <= ({r_phy, w_sd} == PHY_ADDR);
          end
          S_REGAD: begin
            r_regad <= w_ra;
            if (r_bit == 5'd13) r_rdata <= w_rd_mux;
          end
          S_TA: begin
            if (w_rd) begin
              if (r_bit == 5'd14) begin
                r_oen <= 1'b0;
                r_out <= 1'b0;
              end else begin
                r_out   <= r_rdata[15];
                r_rdata <= {r_rdata[14:0], 1'b0};
              end
            end
          end
          S_DATA: begin
            r_wdata <= w_wdat[14:0];
            if (r_bit == 5'd31) begin
              r_oen <= 1'b1;
              r_out <= 1'b1;
              if (w_wr) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_regad;
                r_wr_data  <= w_wdat;
                // Bit 15 of the control register is a self-clearing soft reset.
                if (r_regad == 5'd0) begin
                  if (w_wdat[15]) begin
                    r_reg0 <= CTRL_DEF;
                    for (int i = 0; i < 4; i++) r_rw[i] <= 16'h0000;
                  end else begin
                    r_reg0 <= {1'b0, w_wdat[14:0]};
                  end
                end else if (r_regad[4:2] == 3'b001) begin
                  r_rw[r_regad[1:0]] <= w_wdat;
                end
              end
            end else if (w_rd) begin
              r_out   <= r_rdata[15];
              r_rdata <= {r_rdata[14:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mdio_out  = r_out;
  assign mdio_oen  = r_oen;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: drives Clause-22 frames from a master model and
// checks the line and write reports against a register-level model.
module tb_mdio_phy_responder;
  localparam logic [4:0] PHY_ADDR = 5'd0;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        mdc = 1'b0;
  logic        link_up = 1'b0;
  logic        m_oe = 1'b1;
  logic        m_bit = 1'b1;
  logic        mdio_in;
  logic        mdio_out, mdio_oen, wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_state;

  // Open-drain style bus with a pull-up: master, DUT, or idle high.
  assign mdio_in = m_oe ? m_bit : (mdio_oen ? 1'b1 : mdio_out);

  mdio_phy_responder #(.PHY_ADDR(PHY_ADDR)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .mdc(mdc),
    .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_oen(mdio_oen),
    .link_up(link_up), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_state(dbg_state)
  );

  always #5 clk_clk = ~clk_clk;

  int          errors = 0;
  int          checks = 0;
  logic        line_chk = 1'b0;
  logic        exp_oen, exp_out;
  int          cur_k;
  string       cur_tag;
  logic [20:0] exp_q[$];
  logic [15:0] m_reg0;
  logic [15:0] m_rw [4];
  logic [15:0] rd_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a == 5'd0) v = m_reg0;
    else if (a == 5'd1) v = link_up ? 16'h794D : 16'h7949;
    else if (a == 5'd2) v = 16'h0141;
    else if (a == 5'd3) v = 16'h0DD1;
    else if (a >= 5'd4 && a <= 5'd7) v = m_rw[a - 5'd4];
    return v;
  endfunction

  task automatic model_reset();
    m_reg0 = 16'h1140;
    for (int i = 0; i < 4; i++) m_rw[i] = 16'h0000;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d[15]) model_reset();
      else m_reg0 = d;
    end else if (a >= 5'd4 && a <= 5'd7) begin
      m_rw[a - 5'd4] = d;
    end
  endtask

  // Single compare process: line state once per MDC bit, write reports every cycle.
  always @(negedge clk_clk) begin
    if (line_chk) begin
      line_chk = 1'b0;
      checks++;
      if ({mdio_oen, mdio_out} !== {exp_oen, exp_out}) begin
        errors++;
        $display("FAIL line %s k=%0d oen/out actual=%b%b required=%b%b",
                 cur_tag, cur_k, mdio_oen, mdio_out, exp_oen, exp_out);
      end
    end
    if (wr_valid !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual addr=%h data=%h required no pulse", wr_addr, wr_data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, e}) begin
          errors++;
          $display("FAIL wr_report actual=%b/%h/%h required=1/%h/%h",
                   wr_valid, wr_addr, wr_data, e[20:16], e[15:0]);
        end
      end
    end
  end

  // One MDC period: falling edge at entry, master drives, rising edge 80 ns later.
  task automatic frame(input string tag, input int pre, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int rst_k);
    logic [31:0] bits;
    logic        ans, is_rd, is_wr, dead, eo, ev, drv;
    logic [15:0] rd;
    bits  = {2'b01, op, phy, ra, 2'b10, wd};
    ans   = (pre >= 32) && (phy == PHY_ADDR);
    is_rd = ans && (op == 2'b10);
    is_wr = ans && (op == 2'b01);
    rd    = model_read(ra);
    dead  = 1'b0;
    rd_cap = 16'h0000;
    cur_tag = tag;
    for (int n = 0; n < pre + 32; n++) begin
      int k;
      k  = n - pre;
      eo = 1'b1;
      ev = 1'b1;
      if (k >= 0 && is_rd && !dead && k >= 14 && k <= 30) begin
        eo = 1'b0;
        ev = (k == 14) ? 1'b0 : rd[30 - k];
      end
      if (k == 31 && is_wr && !dead) begin
        model_write(ra, wd);
        exp_q.push_back({ra, wd});
      end
      drv = (k < 0) ? 1'b1 : !(op == 2'b10 && k >= 14);
      mdc  = 1'b0;
      m_oe = drv;
      m_bit = (k < 0) ? 1'b1 : bits[31 - k];
      #80 mdc = 1'b1;
      #60;
      cur_k = k;
      exp_oen = eo;
      exp_out = ev;
      line_chk = 1'b1;
      if (k >= 15 && k <= 30) rd_cap[30 - k] = mdio_out;
      #10;
      if (k >= 0 && k == rst_k) begin
        reset_reset = 1'b1;
        #2;
        chk("rst_mid_oen", {31'd0, mdio_oen}, 32'd1);
        chk("rst_mid_out", {31'd0, mdio_out}, 32'd1);
        chk("rst_mid_wr", {5'd0, wr_valid, wr_addr, wr_data}, 32'd0);
        #1 reset_reset = 1'b0;
        dead = 1'b1;
        model_reset();
        exp_q.delete();
        #7;
      end else begin
        #10;
      end
    end
    mdc  = 1'b0;
    m_oe = 1'b1;
    m_bit = 1'b1;
    chk({tag, "_wr_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    model_reset();
    #32;
    chk("reset_oen", {31'd0, mdio_oen}, 32'd1);
    chk("reset_out", {31'd0, mdio_out}, 32'd1);
    chk("reset_wr", {5'd0, wr_valid, wr_addr, wr_data}, 32'd0);
    reset_reset = 1'b0;
    #50;

    frame("rd_id1", 32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    chk("id1", rd_cap, 32'h0141);

    frame("wr_r5", 32, 2'b01, 5'd0, 5'd5, 16'hA55A, -1);
    frame("rd_r5", 32, 2'b10, 5'd0, 5'd5, 16'h0, -1);
    chk("r5_readback", rd_cap, 32'hA55A);

    frame("rd_wrongad", 32, 2'b10, 5'd3, 5'd2, 16'h0, -1);
    frame("wr_wrongad", 32, 2'b01, 5'd3, 5'd5, 16'h0000, -1);
    frame("rd_r5_again", 32, 2'b10, 5'd0, 5'd5, 16'h0, -1);
    chk("r5_after_wrongad", rd_cap, 32'hA55A);

    frame("rd_short_pre", 31, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    frame("rd_full_pre", 32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    chk("id1_full_pre", rd_cap, 32'h0141);

    frame("op11", 32, 2'b11, 5'd0, 5'd4, 16'hFFFF, -1);

    frame("wr_r4", 32, 2'b01, 5'd0, 5'd4, 16'h1234, -1);
    frame("rd_r4", 32, 2'b10, 5'd0, 5'd4, 16'h0, -1);
    chk("r4_written", rd_cap, 32'h1234);
    frame("wr_softrst", 32, 2'b01, 5'd0, 5'd0, 16'h8000, -1);
    frame("rd_r0", 32, 2'b10, 5'd0, 5'd0, 16'h0, -1);
    chk("r0_after_softrst", rd_cap, 32'h1140);
    frame("rd_r4b", 32, 2'b10, 5'd0, 5'd4, 16'h0, -1);
    chk("r4_after_softrst", rd_cap, 32'h0000);
    frame("rd_r5b", 32, 2'b10, 5'd0, 5'd5, 16'h0, -1);
    chk("r5_after_softrst", rd_cap, 32'h0000);

    frame("wr_r0", 32, 2'b01, 5'd0, 5'd0, 16'h2100, -1);
    frame("rd_r0b", 32, 2'b10, 5'd0, 5'd0, 16'h0, -1);
    chk("r0_written", rd_cap, 32'h2100);

    link_up = 1'b1;
    frame("rd_r1_up", 32, 2'b10, 5'd0, 5'd1, 16'h0, -1);
    chk("r1_link_up", rd_cap, 32'h794D);
    link_up = 1'b0;
    frame("rd_r1_dn", 32, 2'b10, 5'd0, 5'd1, 16'h0, -1);
    chk("r1_link_down", rd_cap, 32'h7949);

    frame("wr_r9", 32, 2'b01, 5'd0, 5'd9, 16'h5A5A, -1);
    frame("rd_r9", 32, 2'b10, 5'd0, 5'd9, 16'h0, -1);
    chk("r9_reads_zero", rd_cap, 32'h0000);

    frame("wr_r6", 32, 2'b01, 5'd0, 5'd6, 16'hBEEF, -1);
    frame("rd_r6_rst", 32, 2'b10, 5'd0, 5'd6, 16'h0, 24);
    frame("rd_r6_after", 32, 2'b10, 5'd0, 5'd6, 16'h0, -1);
    chk("r6_after_hwrst", rd_cap, 32'h0000);
    frame("rd_id2", 32, 2'b10, 5'd0, 5'd3, 16'h0, -1);
    chk("id2_after_hwrst", rd_cap, 32'h0DD1);
    frame("rd_r0_after", 32, 2'b10, 5'd0, 5'd0, 16'h0, -1);
    chk("r0_after_hwrst", rd_cap, 32'h1140);

    frame("wr_r7", 32, 2'b01, 5'd0, 5'd7, 16'hC3A5, -1);
    frame("rd_r2_last", 32, 2'b10, 5'd0, 5'd2, 16'h0, -1);
    chk("wr_hold", {11'd0, wr_addr, wr_data}, {11'd0, 5'd7, 16'hC3A5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
